// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - request/response handshake bundle between an op issuer and alu_seq
interface alu_seq_if;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] req_op;
    logic [7:0] req_a;
    logic [7:0] req_b;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic       res_wb;

    modport master (
        output req_valid, req_op, req_a, req_b, res_ready,
        input  req_ready, res_valid, res_data, res_wb
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, res_ready,
        output req_ready, res_valid, res_data, res_wb
    );
endinterface

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - 6502 op sequencer: drives the external ALU, captures its result, owns P
module alu_seq #(
    parameter logic [7:0] P_RESET = 8'h24
) (
    input  logic       clk,
    input  logic       reset,
    alu_seq_if.slave   bus,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [4:0] alu_mode,
    output logic       alu_carry_in,
    input  logic [7:0] alu_out,
    input  logic       alu_carry_out,
    output logic [7:0] p_flags,
    input  logic       p_load,
    input  logic [7:0] p_load_data
);
    localparam logic [3:0] OP_ADC = 4'd0,  OP_SBC = 4'd1,  OP_CMP = 4'd2,  OP_AND = 4'd3;
    localparam logic [3:0] OP_ORA = 4'd4,  OP_EOR = 4'd5,  OP_ASL = 4'd6,  OP_ROL = 4'd7;
    localparam logic [3:0] OP_LSR = 4'd8,  OP_ROR = 4'd9,  OP_INC = 4'd10, OP_DEC = 4'd11;
    localparam logic [3:0] OP_BIT = 4'd12;

    localparam logic [4:0] MODE_ADD  = 5'd0;
    localparam logic [4:0] MODE_AND  = 5'd1;
    localparam logic [4:0] MODE_OR   = 5'd2;
    localparam logic [4:0] MODE_EOR  = 5'd3;
    localparam logic [4:0] MODE_PASS = 5'd31;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPTURE, S_DONE} state_t;

    state_t     state, state_nxt;
    logic [3:0] op_q;
    logic [7:0] a_q, b_q;
    logic       c_q;
    logic [7:0] drv_b;
    logic [4:0] drv_mode;
    logic       drv_cin;
    logic [7:0] res_nxt;
    logic       wb_nxt;
    logic [7:0] flags_nxt;
    logic [7:0] res_data_q;
    logic       res_wb_q;

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        bus.req_ready = 1'b0;
        bus.res_valid = 1'b0;
        alu_a         = 8'h00;
        alu_b         = 8'h00;
        alu_mode      = 5'd0;
        alu_carry_in  = 1'b0;
        case (state)
            S_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                alu_a        = a_q;
                alu_b        = drv_b;
                alu_mode     = drv_mode;
                alu_carry_in = drv_cin;
                state_nxt    = S_CAPTURE;
            end
            S_CAPTURE: state_nxt = S_DONE;
            S_DONE: begin
                bus.res_valid = 1'b1;
                if (bus.res_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Carry is sampled at acceptance so a p_load during the op cannot alter its inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q <= 4'd0;
            a_q  <= 8'h00;
            b_q  <= 8'h00;
            c_q  <= 1'b0;
        end else if (state == S_IDLE && bus.req_valid) begin
            op_q <= bus.req_op;
            a_q  <= bus.req_a;
            b_q  <= bus.req_b;
            c_q  <= p_flags[0];
        end
    end

    always_comb begin
        drv_b    = 8'h00;
        drv_mode = MODE_PASS;
        drv_cin  = 1'b0;
        case (op_q)
            OP_ADC: begin drv_mode = MODE_ADD; drv_b = b_q;  drv_cin = c_q;  end
            OP_SBC: begin drv_mode = MODE_ADD; drv_b = ~b_q; drv_cin = c_q;  end
            OP_CMP: begin drv_mode = MODE_ADD; drv_b = ~b_q; drv_cin = 1'b1; end
            OP_AND: begin drv_mode = MODE_AND; drv_b = b_q; end
            OP_ORA: begin drv_mode = MODE_OR;  drv_b = b_q; end
            OP_EOR: begin drv_mode = MODE_EOR; drv_b = b_q; end
            OP_ASL: begin drv_mode = MODE_ADD; drv_b = a_q;  drv_cin = 1'b0; end
            OP_ROL: begin drv_mode = MODE_ADD; drv_b = a_q;  drv_cin = c_q;  end
            OP_INC: begin drv_mode = MODE_ADD; drv_b = 8'h00; drv_cin = 1'b1; end
            OP_DEC: begin drv_mode = MODE_ADD; drv_b = 8'hFF; drv_cin = 1'b0; end
            OP_BIT: begin drv_mode = MODE_AND; drv_b = b_q; end
            default: begin drv_mode = MODE_PASS; end
        endcase
    end

    // Shifts right and the undefined ops never use the ALU result.
    always_comb begin
        res_nxt   = alu_out;
        wb_nxt    = 1'b1;
        flags_nxt = p_flags;
        case (op_q)
            OP_ADC, OP_SBC: begin
                flags_nxt[0] = alu_carry_out;
                flags_nxt[6] = (a_q[7] == drv_b[7]) && (alu_out[7] != a_q[7]);
            end
            OP_CMP: begin
                flags_nxt[0] = alu_carry_out;
                wb_nxt       = 1'b0;
            end
            OP_ASL, OP_ROL: flags_nxt[0] = alu_carry_out;
            OP_LSR: begin
                res_nxt      = {1'b0, a_q[7:1]};
                flags_nxt[0] = a_q[0];
            end
            OP_ROR: begin
                res_nxt      = {c_q, a_q[7:1]};
                flags_nxt[0] = a_q[0];
            end
            OP_AND, OP_ORA, OP_EOR, OP_INC, OP_DEC: ;
            OP_BIT: begin
                wb_nxt       = 1'b0;
                flags_nxt[6] = b_q[6];
            end
            default: begin
                res_nxt = a_q;
                wb_nxt  = 1'b0;
            end
        endcase
        if (op_q <= OP_BIT) begin
            flags_nxt[1] = (res_nxt == 8'h00);
            flags_nxt[7] = (op_q == OP_BIT) ? b_q[7] : res_nxt[7];
        end
        flags_nxt[5] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            res_data_q <= 8'h00;
            res_wb_q   <= 1'b0;
            p_flags    <= P_RESET;
        end else begin
            if (state == S_CAPTURE) begin
                res_data_q <= res_nxt;
                res_wb_q   <= wb_nxt;
            end
            if (p_load)
                p_flags <= p_load_data | 8'h20;
            else if (state == S_CAPTURE)
                p_flags <= flags_nxt;
        end
    end

    assign bus.res_data = res_data_q;
    assign bus.res_wb   = res_wb_q;
endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - randomized self-checking bench for alu_seq against an arithmetic 6502 model
module tb_alu_seq;
    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] alu_a, alu_b, alu_out;
    logic [4:0] alu_mode;
    logic       alu_carry_in, alu_carry_out;
    logic [7:0] p_flags;
    logic       p_load;
    logic [7:0] p_load_data;
    logic [8:0] alu_sum;

    alu_seq_if bus ();

    alu_seq dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus.slave),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_mode      (alu_mode),
        .alu_carry_in  (alu_carry_in),
        .alu_out       (alu_out),
        .alu_carry_out (alu_carry_out),
        .p_flags       (p_flags),
        .p_load        (p_load),
        .p_load_data   (p_load_data)
    );

    always #5 clk = ~clk;

    // Registered external ALU
    assign alu_sum = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_carry_in};
    always @(posedge clk) begin
        case (alu_mode)
            5'd0:    begin alu_out <= alu_sum[7:0];    alu_carry_out <= alu_sum[8]; end
            5'd1:    begin alu_out <= alu_a & alu_b;   alu_carry_out <= 1'b0; end
            5'd2:    begin alu_out <= alu_a | alu_b;   alu_carry_out <= 1'b0; end
            5'd3:    begin alu_out <= alu_a ^ alu_b;   alu_carry_out <= 1'b0; end
            default: begin alu_out <= alu_a;           alu_carry_out <= 1'b0; end
        endcase
    end

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] p_model;
    logic [7:0] last_res, last_p;
    logic       last_wb;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void ref_model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                      input logic [7:0] p, output logic [7:0] r,
                                      output logic [7:0] pn, output logic wb);
        int c, s, sv;
        c  = int'(p[0]);
        pn = p;
        wb = 1'b1;
        r  = a;
        case (op)
            4'd0: begin
                s  = int'(a) + int'(b) + c;
                sv = int'($signed(a)) + int'($signed(b)) + c;
                r = s[7:0]; pn[0] = (s > 255); pn[6] = (sv > 127) || (sv < -128);
            end
            4'd1: begin
                s  = int'(a) - int'(b) - (1 - c);
                sv = int'($signed(a)) - int'($signed(b)) - (1 - c);
                r = s[7:0]; pn[0] = (s >= 0); pn[6] = (sv > 127) || (sv < -128);
            end
            4'd2: begin
                s = int'(a) - int'(b);
                r = s[7:0]; pn[0] = (a >= b); wb = 1'b0;
            end
            4'd3:  r = a & b;
            4'd4:  r = a | b;
            4'd5:  r = a ^ b;
            4'd6:  begin r = {a[6:0], 1'b0}; pn[0] = a[7]; end
            4'd7:  begin r = {a[6:0], p[0]}; pn[0] = a[7]; end
            4'd8:  begin r = {1'b0, a[7:1]}; pn[0] = a[0]; end
            4'd9:  begin r = {p[0], a[7:1]}; pn[0] = a[0]; end
            4'd10: r = a + 8'd1;
            4'd11: r = a - 8'd1;
            4'd12: begin r = a & b; wb = 1'b0; pn[6] = b[6]; end
            default: begin r = a; wb = 1'b0; end
        endcase
        if (op <= 4'd12) begin
            pn[1] = (r == 8'h00);
            pn[7] = (op == 4'd12) ? b[7] : r[7];
        end
    endfunction

    task automatic do_pload(input logic [7:0] d);
        @(negedge clk);
        p_load = 1'b1; p_load_data = d;
        @(negedge clk);
        p_load = 1'b0;
        p_model = d | 8'h20;
        check("p_load", p_flags, p_model);
    endtask

    task automatic run_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                          input int stall, input bit hold_req, input bit cap_load,
                          input logic [7:0] pl_data);
        logic [7:0] exp_r, exp_p;
        logic       exp_wb;
        int         lat;
        ref_model(op, a, b, p_model, exp_r, exp_p, exp_wb);
        if (cap_load) exp_p = pl_data | 8'h20;
        @(negedge clk);
        check("req_ready_idle", bus.req_ready, 1);
        bus.req_valid = 1'b1; bus.req_op = op; bus.req_a = a; bus.req_b = b;
        bus.res_ready = (stall == 0);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        lat = 0;
        forever begin
            @(negedge clk);
            if (bus.res_valid || lat > 8) break;
            p_load = cap_load && (lat == 1);
            p_load_data = pl_data;
            lat++;
        end
        p_load = 1'b0;
        check("latency", lat, 2);
        check("res_data", bus.res_data, exp_r);
        check("res_wb", bus.res_wb, exp_wb);
        check("p_flags", p_flags, exp_p);
        check("alu_quiet", {alu_a, alu_b}, 16'h0000);
        last_res = bus.res_data; last_p = p_flags; last_wb = bus.res_wb;
        for (int k = 0; k < stall; k++) begin
            bus.req_valid = hold_req;
            @(negedge clk);
            check("stall_valid", bus.res_valid, 1);
            check("stall_data", {bus.res_wb, bus.res_data}, {exp_wb, exp_r});
            check("stall_ready", bus.req_ready, 0);
        end
        bus.req_valid = 1'b0;
        bus.res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("handshake", {bus.res_valid, bus.req_ready}, 2'b01);
        p_model = exp_p;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; p_load = 1'b0; p_load_data = 8'h00;
        bus.req_valid = 1'b0; bus.req_op = 4'd0; bus.req_a = 8'h00; bus.req_b = 8'h00;
        bus.res_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_p", p_flags, 8'h24);
        check("rst_res_valid", bus.res_valid, 0);
        check("rst_req_ready", bus.req_ready, 1);
        check("rst_alu", {alu_a, alu_b}, 16'h0000);
        check("rst_res", {bus.res_wb, bus.res_data}, 9'h000);
        reset = 1'b0;
        p_model = 8'h24;

        run_op(4'd0, 8'h50, 8'h50, 0, 0, 0, 8'h00);
        check("adc_spec_r", last_res, 8'hA0);
        check("adc_spec_f", last_p & 8'hC3, 8'hC0);
        check("adc_spec_wb", last_wb, 1);

        do_pload(8'h25);
        run_op(4'd1, 8'h00, 8'h01, 0, 0, 0, 8'h00);
        check("sbc_spec", {last_res, last_p & 8'hC1}, {8'hFF, 8'h80});
        run_op(4'd2, 8'h40, 8'h40, 1, 0, 0, 8'h00);
        check("cmp_spec", {last_wb, last_p & 8'hC3}, {1'b0, 8'h03});

        do_pload(8'h25);
        run_op(4'd9, 8'h01, 8'h00, 0, 0, 0, 8'h00);
        check("ror_spec", {last_res, last_p & 8'h81}, {8'h80, 8'h81});
        run_op(4'd8, 8'h01, 8'h00, 0, 0, 0, 8'h00);
        check("lsr_spec", {last_res, last_p & 8'h83}, {8'h00, 8'h03});
        run_op(4'd10, 8'hFF, 8'h00, 0, 0, 0, 8'h00);
        check("inc_spec", {last_res, last_p & 8'h83}, {8'h00, 8'h03});
        run_op(4'd11, 8'h00, 8'h00, 0, 0, 0, 8'h00);
        check("dec_spec", last_res, 8'hFF);

        run_op(4'd12, 8'h0F, 8'hC0, 5, 1, 0, 8'h00);
        check("bit_spec", {last_wb, last_p & 8'hC2}, {1'b0, 8'hC2});

        run_op(4'd0, 8'h12, 8'h34, 0, 0, 1, 8'h01);
        check("pload_wins", last_p, 8'h21);

        // Reset while the op sits in ISSUE
        do_pload(8'hC3);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_op = 4'd0; bus.req_a = 8'hFF; bus.req_b = 8'h01;
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_issue_ready", bus.req_ready, 1);
        check("rst_issue_p", p_flags, 8'h24);
        p_model = 8'h24;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("rst_issue_novalid", bus.res_valid, 0);
        end
        check("rst_issue_p2", p_flags, 8'h24);

        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 7) == 0) do_pload(8'($urandom));
            run_op(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom),
                   int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 9) == 0), 8'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
